// File: rtl/dmc_line_filler_pkg.sv
// Shared constants for the DMC line filler: bus geometry and FSM state encoding.
package dmc_line_filler_pkg;

    localparam int unsigned ADDR_W   = 24;
    localparam int unsigned LINE_W   = 128;
    localparam int unsigned BEAT_W   = 32;
    localparam int unsigned BEATS    = 4;
    localparam int unsigned BEAT_IDX = 2;
    localparam int unsigned OFFS_W   = 4;
    localparam int unsigned LADDR_W  = ADDR_W - OFFS_W;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FILL  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;

endpackage

// File: rtl/dmc_line_filler.sv
// Cache line filler: on a miss, fetches four 32-bit words in order and writes one 128-bit line.
module dmc_line_filler
    import dmc_line_filler_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req,
    input  logic [ADDR_W-1:0]   A,
    input  logic                hit,
    output logic                ready,
    output logic                mem_rd,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [BEAT_W-1:0]   mem_rdata,
    input  logic                mem_ack,
    output logic [ADDR_W-1:0]   fill_A,
    output logic [LINE_W-1:0]   line,
    output logic                wr,
    output logic                busy,
    output logic [CNT_W-1:0]    miss_cnt
);

    logic [1:0]          state_q, state_d;
    logic [BEAT_IDX-1:0] beat_q, beat_d;
    logic [LADDR_W-1:0]  line_addr_q, line_addr_d;
    logic [CNT_W-1:0]    miss_cnt_q, miss_cnt_d;
    logic [BEAT_W-1:0]   beat_data_q [BEATS];
    logic                capture;

    // The byte offset within the line never reaches the memory side.
    logic [OFFS_W-1:0]   unused_offset;
    assign unused_offset = A[OFFS_W-1:0];

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        line_addr_d = line_addr_q;
        miss_cnt_d  = miss_cnt_q;
        capture     = 1'b0;
        case (state_q)
            IDLE: begin
                if (req && !hit) begin
                    line_addr_d = A[ADDR_W-1:OFFS_W];
                    beat_d      = '0;
                    if (miss_cnt_q != {CNT_W{1'b1}}) begin
                        miss_cnt_d = miss_cnt_q + CNT_W'(1);
                    end
                    state_d = FILL;
                end
            end
            FILL: begin
                if (mem_ack) begin
                    capture = 1'b1;
                    beat_d  = beat_q + BEAT_IDX'(1);
                    if (beat_q == BEAT_IDX'(BEATS - 1)) begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            line_addr_q <= '0;
            miss_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            line_addr_q <= line_addr_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    // One register per beat; a word lands in the slot selected by the current beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BEATS; i++) begin
                beat_data_q[i] <= '0;
            end
        end else if (capture) begin
            beat_data_q[beat_q] <= mem_rdata;
        end
    end

    always_comb begin
        ready    = (state_q == IDLE) && (!req || hit);
        mem_rd   = (state_q == FILL);
        mem_addr = (state_q == FILL) ? {line_addr_q, beat_q, 2'b00} : '0;
        fill_A   = (state_q != IDLE) ? {line_addr_q, {OFFS_W{1'b0}}} : '0;
        wr       = (state_q == WRITE);
        busy     = (state_q != IDLE);
        line     = {beat_data_q[3], beat_data_q[2], beat_data_q[1], beat_data_q[0]};
        miss_cnt = miss_cnt_q;
    end

endmodule

// File: tb/tb_dmc_line_filler.sv
// Self-checking bench for dmc_line_filler: per-cycle model compare plus directed literal checks.
module tb_dmc_line_filler;

    logic         clk;
    logic         rst_n;
    logic         req;
    logic [23:0]  A;
    logic         hit;
    logic         mem_ack;
    logic [31:0]  mem_rdata;
    logic [7:0]   tag;

    logic         ready, mem_rd, wr, busy;
    logic [23:0]  mem_addr, fill_A;
    logic [127:0] line;
    logic [15:0]  miss_cnt;

    logic         s_ready, s_mem_rd, s_wr, s_busy;
    logic [23:0]  s_mem_addr, s_fill_A;
    logic [127:0] s_line;
    logic [1:0]   s_miss_cnt;

    int n_chk;
    int n_fail;

    // Memory returns a tagged echo of the requested word address.
    assign mem_rdata = {tag, mem_addr};

    dmc_line_filler #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .A(A), .hit(hit), .ready(ready),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .fill_A(fill_A), .line(line), .wr(wr), .busy(busy), .miss_cnt(miss_cnt)
    );

    dmc_line_filler #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .req(req), .A(A), .hit(hit), .ready(s_ready),
        .mem_rd(s_mem_rd), .mem_addr(s_mem_addr), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .fill_A(s_fill_A), .line(s_line), .wr(s_wr), .busy(s_busy), .miss_cnt(s_miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a fill is "how many words have arrived so far", plus a one-cycle write phase.
    logic        m_fill, m_write;
    int          m_acks;
    int          m_cnt;
    logic [19:0] m_laddr;
    logic [31:0] m_words [4];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_fill  <= 1'b0;
            m_write <= 1'b0;
            m_acks  <= 0;
            m_cnt   <= 0;
            m_laddr <= '0;
            for (int i = 0; i < 4; i++) m_words[i] <= '0;
        end else if (m_write) begin
            m_write <= 1'b0;
        end else if (m_fill) begin
            if (mem_ack) begin
                m_words[m_acks] <= mem_rdata;
                m_acks <= m_acks + 1;
                if (m_acks == 3) begin
                    m_fill  <= 1'b0;
                    m_write <= 1'b1;
                end
            end
        end else if (req && !hit) begin
            m_fill  <= 1'b1;
            m_acks  <= 0;
            m_laddr <= A[23:4];
            m_cnt   <= m_cnt + 1;
        end
    end

    always @(negedge clk) begin
        logic          e_busy;
        logic [23:0]   e_addr, e_fa;
        logic [127:0]  e_line;
        int            e_sat;
        e_busy = m_fill || m_write;
        e_addr = m_fill ? (m_laddr * 24'd16 + 24'(m_acks * 4)) : 24'd0;
        e_fa   = e_busy ? m_laddr * 24'd16 : 24'd0;
        e_line = {m_words[3], m_words[2], m_words[1], m_words[0]};
        e_sat  = (m_cnt > 3) ? 3 : m_cnt;
        chk("ready",    128'(ready),    128'(!e_busy && (!req || hit)));
        chk("mem_rd",   128'(mem_rd),   128'(m_fill));
        chk("mem_addr", 128'(mem_addr), 128'(e_addr));
        chk("fill_A",   128'(fill_A),   128'(e_fa));
        chk("wr",       128'(wr),       128'(m_write));
        chk("busy",     128'(busy),     128'(e_busy));
        chk("line",     line,           e_line);
        chk("miss_cnt", 128'(miss_cnt), 128'(m_cnt));
        chk("sat_busy", 128'(s_busy),   128'(e_busy));
        chk("sat_addr", 128'({s_ready, s_mem_rd, s_wr, s_mem_addr, s_fill_A}),
            128'({ready, mem_rd, wr, e_addr, e_fa}));
        chk("sat_line", s_line,         e_line);
        chk("sat_cnt",  128'(s_miss_cnt), 128'(e_sat));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic zero_wait_miss(input logic [23:0] addr);
        req = 1'b1; hit = 1'b0; A = addr; mem_ack = 1'b1;
        tick();
        req = 1'b0;
        for (int i = 0; i < 5; i++) tick();
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        rst_n = 1'b0; req = 1'b0; A = '0; hit = 1'b0; mem_ack = 1'b0; tag = 8'hA5;
        tick();
        @(negedge clk);
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_line", line, 128'(0));
        #1;
        do_reset();

        // Zero-wait miss at 0x001234
        req = 1'b1; A = 24'h001234; hit = 1'b0; mem_ack = 1'b1;
        @(negedge clk);
        chk("miss_ready0", 128'(ready), 128'(0));
        tick();
        req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("zw_addr", 128'(mem_addr), 128'(24'h001230 + 24'(4 * i)));
            tick();
        end
        @(negedge clk);
        chk("zw_wr", 128'(wr), 128'(1));
        chk("zw_fillA", 128'(fill_A), 128'(24'h001230));
        chk("zw_line", line, 128'h A500123C_A5001238_A5001234_A5001230);
        tick();
        @(negedge clk);
        chk("zw_ready6", 128'(ready), 128'(1));
        chk("zw_cnt", 128'(miss_cnt), 128'(1));
        chk("zw_fillA_idle", 128'(fill_A), 128'(0));
        chk("zw_line_hold", line, 128'h A500123C_A5001238_A5001234_A5001230);

        // Hit in IDLE
        tick();
        req = 1'b1; hit = 1'b1; A = 24'h001234;
        @(negedge clk);
        chk("hit_ready", 128'(ready), 128'(1));
        chk("hit_rd", 128'(mem_rd), 128'(0));
        tick();
        @(negedge clk);
        chk("hit_cnt", 128'(miss_cnt), 128'(1));
        chk("hit_busy", 128'(busy), 128'(0));
        tick();

        // Wait states 0,0,1,0,1,1,0,1
        begin
            logic [7:0] pat;
            int k;
            pat = 8'b1011_0100;
            k = 0;
            tag = 8'h3C;
            req = 1'b1; hit = 1'b0; A = 24'h000458; mem_ack = 1'b0;
            tick();
            req = 1'b0;
            for (int i = 0; i < 8; i++) begin
                mem_ack = pat[i];
                @(negedge clk);
                chk("ws_addr", 128'(mem_addr), 128'(24'h000450 + 24'(4 * k)));
                chk("ws_nowr", 128'(wr), 128'(0));
                tick();
                if (pat[i]) k++;
            end
            mem_ack = 1'b0;
            @(negedge clk);
            chk("ws_wr", 128'(wr), 128'(1));
            chk("ws_line", line, 128'h 3C00045C_3C000458_3C000454_3C000450);
            chk("ws_cnt", 128'(miss_cnt), 128'(2));
            tick();
        end

        // Address change mid-fill
        tag = 8'h11;
        req = 1'b1; hit = 1'b0; A = 24'h0000F0; mem_ack = 1'b0;
        tick();
        A = 24'h7FFFF0;
        @(negedge clk);
        chk("ac_hold", 128'(mem_addr), 128'(24'h0000F0));
        tick();
        mem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("ac_addr", 128'(mem_addr), 128'(24'h0000F0 + 24'(4 * i)));
            chk("ac_fillA", 128'(fill_A), 128'(24'h0000F0));
            tick();
        end
        @(negedge clk);
        chk("ac_wr", 128'(wr), 128'(1));
        chk("ac_fillA_w", 128'(fill_A), 128'(24'h0000F0));
        req = 1'b0;
        tick();

        // Reset mid-fill after two beats
        tag = 8'h77;
        req = 1'b1; hit = 1'b0; A = 24'h002000; mem_ack = 1'b1;
        tick();
        req = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("ar_busy", 128'(busy), 128'(0));
        chk("ar_rd", 128'(mem_rd), 128'(0));
        chk("ar_addr", 128'(mem_addr), 128'(0));
        chk("ar_fillA", 128'(fill_A), 128'(0));
        chk("ar_line", line, 128'(0));
        chk("ar_cnt", 128'(miss_cnt), 128'(0));
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("ar_nowr", 128'(wr), 128'(0));
            chk("ar_nocap", line, 128'(0));
            tick();
        end
        mem_ack = 1'b0;

        // Saturation with CNT_W=2
        do_reset();
        for (int i = 0; i < 5; i++) begin
            zero_wait_miss(24'h010000 + 24'(i * 16));
            @(negedge clk);
            chk("sat_lit", 128'(s_miss_cnt), 128'((i < 3) ? i + 1 : 3));
            chk("sat_wide", 128'(miss_cnt), 128'(i + 1));
        end
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
